// File: rtl/sha2_compress_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_compress_iter_if
//  Description : Bus bundle for the iterative SHA-2 compression engine.
//                start/ready handshake, block and chaining-value inputs,
//                round-constant ROM lookup (k_idx out, k_in back), and the
//                done/hash_out result.
//                slave  : the engine side
//                master : the driver / K-ROM side
//  Revision    : 1.0  initial release
// ============================================================================
interface sha2_compress_iter_if #(
  parameter int WORDSIZE = 32
);
  localparam int ROUNDS = (WORDSIZE == 64) ? 80 : 64;
  localparam int CW     = $clog2(ROUNDS);

  logic                    start;
  logic                    ready;
  logic [8*WORDSIZE-1:0]   init_hash;
  logic [16*WORDSIZE-1:0]  block_in;
  logic [CW-1:0]           k_idx;
  logic [WORDSIZE-1:0]     k_in;
  logic                    done;
  logic [8*WORDSIZE-1:0]   hash_out;

  modport slave (
    input  start, init_hash, block_in, k_in,
    output ready, k_idx, done, hash_out
  );

  modport master (
    output start, init_hash, block_in, k_in,
    input  ready, k_idx, done, hash_out
  );
endinterface
`default_nettype wire

// File: rtl/sha2_compress_iter.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_compress_iter
//  Description : Iterative SHA-2 compression, one round per clock, for
//                SHA-256 (WORDSIZE=32, 64 rounds) or SHA-512 (WORDSIZE=64,
//                80 rounds). Holds working variables a..h, a 16-word rolling
//                message schedule, the saved chaining value and the round
//                counter; round constants are fetched from an external ROM.
//  Ports       : clk        clock
//                rst_n      asynchronous active-low reset
//                bus.start/ready       job handshake (accepted while ready)
//                bus.init_hash         H0..H7, H0 in MSBs
//                bus.block_in          M0..M15, M0 in MSBs
//                bus.k_idx / bus.k_in  round-constant ROM lookup
//                bus.done / hash_out   one-cycle pulse with result
//  Revision    : 1.0  initial release
// ============================================================================
module sha2_compress_iter #(
  parameter int WORDSIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sha2_compress_iter_if.slave   bus
);

  localparam int ROUNDS = (WORDSIZE == 64) ? 80 : 64;
  localparam int CW     = $clog2(ROUNDS);

  // Rotate / shift amounts for the four SHA-2 sigma functions.
  localparam int BS0_A = (WORDSIZE == 64) ? 28 : 2;
  localparam int BS0_B = (WORDSIZE == 64) ? 34 : 13;
  localparam int BS0_C = (WORDSIZE == 64) ? 39 : 22;
  localparam int BS1_A = (WORDSIZE == 64) ? 14 : 6;
  localparam int BS1_B = (WORDSIZE == 64) ? 18 : 11;
  localparam int BS1_C = (WORDSIZE == 64) ? 41 : 25;
  localparam int SS0_A = (WORDSIZE == 64) ? 1  : 7;
  localparam int SS0_B = (WORDSIZE == 64) ? 8  : 18;
  localparam int SS0_S = (WORDSIZE == 64) ? 7  : 3;
  localparam int SS1_A = (WORDSIZE == 64) ? 19 : 17;
  localparam int SS1_B = (WORDSIZE == 64) ? 61 : 19;
  localparam int SS1_S = (WORDSIZE == 64) ? 6  : 10;

  typedef logic [WORDSIZE-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORDSIZE - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, BS0_A) ^ rotr(x, BS0_B) ^ rotr(x, BS0_C);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, BS1_A) ^ rotr(x, BS1_B) ^ rotr(x, BS1_C);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, SS0_A) ^ rotr(x, SS0_B) ^ (x >> SS0_S);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, SS1_A) ^ rotr(x, SS1_B) ^ (x >> SS1_S);
  endfunction

  // Working variables: v[0]=a ... v[7]=h.
  state_t                state_q, state_d;
  word_t                 v_q  [8];
  word_t                 v_d  [8];
  word_t                 w_q  [16];
  word_t                 w_d  [16];
  word_t                 hs_q [8];
  word_t                 hs_d [8];
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic [8*WORDSIZE-1:0] hash_q, hash_d;

  word_t t1, t2, w_next;

  // Round datapath: W[0] is always the schedule word for the current round,
  // and W[15] is refilled with the word needed sixteen rounds from now.
  always_comb begin
    t1 = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
       + bus.k_in + w_q[0];
    t2 = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    w_next = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    hash_d  = hash_q;
    for (int i = 0; i < 8; i++) begin
      v_d[i]  = v_q[i];
      hs_d[i] = hs_q[i];
    end
    for (int i = 0; i < 16; i++) begin
      w_d[i] = w_q[i];
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < 8; i++) begin
            v_d[i]  = bus.init_hash[(7-i)*WORDSIZE +: WORDSIZE];
            hs_d[i] = bus.init_hash[(7-i)*WORDSIZE +: WORDSIZE];
          end
          for (int i = 0; i < 16; i++) begin
            w_d[i] = bus.block_in[(15-i)*WORDSIZE +: WORDSIZE];
          end
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = ROUND;
        end
      end

      ROUND: begin
        v_d[7] = v_q[6];
        v_d[6] = v_q[5];
        v_d[5] = v_q[4];
        v_d[4] = v_q[3] + t1;
        v_d[3] = v_q[2];
        v_d[2] = v_q[1];
        v_d[1] = v_q[0];
        v_d[0] = t1 + t2;
        for (int i = 0; i < 15; i++) begin
          w_d[i] = w_q[i+1];
        end
        w_d[15] = w_next;
        // Counter returns to 0 on the last round so k_idx reads 0 in FINAL
        // (80 rounds does not wrap a 7-bit counter on its own).
        if (cnt_q == CW'(ROUNDS - 1)) begin
          cnt_d   = '0;
          state_d = FINAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FINAL: begin
        for (int i = 0; i < 8; i++) begin
          hash_d[(7-i)*WORDSIZE +: WORDSIZE] = hs_q[i] + v_q[i];
        end
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      hash_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        v_q[i]  <= '0;
        hs_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      hash_q  <= hash_d;
      for (int i = 0; i < 8; i++) begin
        v_q[i]  <= v_d[i];
        hs_q[i] <= hs_d[i];
      end
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.hash_out = hash_q;
  assign bus.k_idx    = cnt_q;

endmodule
`default_nettype wire
